// File: rtl/alu_pkg.sv
// Shared ALU op encodings and arbiter FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: ADD, SUB, AND, OR and signed set-less-than.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters through an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_src_a,
  input  logic [NREQ*32-1:0]   req_src_b,
  input  logic [NREQ*3-1:0]    req_ctrl,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 busy
);

  localparam int unsigned GW = $clog2(NREQ);

  state_e          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant;
  logic            w_any, w_accept;
  logic [31:0]     r_a, r_b, r_res, w_sel_a, w_sel_b, w_alu_res, w_exec_res;
  logic [2:0]      r_ctrl, w_sel_ctrl;

  assign w_any    = |req_valid;
  assign w_accept = (r_state == StIdle) && w_any;

`ifdef ALU_ARB_RR_EN
  logic [GW-1:0] r_ptr;
  int unsigned   w_idx;

  // Scan downward in distance from the pointer so the nearest valid index wins.
  always_comb begin
    w_grant = '0;
    w_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (req_valid[w_idx]) w_grant = GW'(w_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_grant == GW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
    end
  end
`else
  always_comb begin
    w_grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_grant = GW'(i);
    end
  end
`endif

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == GW'(i)) begin
        w_sel_a    = req_src_a[i*32 +: 32];
        w_sel_b    = req_src_b[i*32 +: 32];
        w_sel_ctrl = req_ctrl[i*3 +: 3];
      end
    end
  end

  alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_ctrl),
    .o_result (w_alu_res)
  );

  // Reserved op codes bypass the ALU and return zero.
  assign w_exec_res = (r_ctrl > ALU_SLT) ? 32'd0 : w_alu_res;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          req_ready[w_grant] = 1'b1;
          w_state_nxt        = StExec;
        end
      end
      StExec: w_state_nxt = StResp;
      StResp: begin
        rsp_valid[r_grant] = 1'b1;
        if (rsp_ready[r_grant]) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant <= w_grant;
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_ctrl  <= w_sel_ctrl;
      end
      if (r_state == StExec) r_res <= w_exec_res;
    end
  end

  assign rsp_result = r_res;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NREQ=3) against a behavioural arbiter/ALU model.
module tb_alu_arbiter;

  localparam int N = 3;
`ifdef ALU_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_src_a = '0;
  logic [N*32-1:0]   req_src_b = '0;
  logic [N*3-1:0]    req_ctrl = '0;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  logic [31:0]       rsp_result;
  logic              busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int model_ptr = 0;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [2:0]  op_c [N];

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(N)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src_a  (req_src_a),
    .req_src_b  (req_src_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_pick(input logic [N-1:0] v);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = RrEn ? (model_ptr + k) % N : k;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [31:0] oh(input int g);
    return 32'd1 << g;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      req_src_a[i*32 +: 32] = op_a[i];
      req_src_b[i*32 +: 32] = op_b[i];
      req_ctrl[i*3 +: 3]    = op_c[i];
    end
  endtask

  // One full accept/execute/respond transaction; bg stays valid while the DUT is busy.
  task automatic transact(input logic [N-1:0] vmask, input logic [N-1:0] bg, input int hold);
    int          g;
    logic [31:0] exp;
    @(negedge clk);
    drive_srcs();
    req_valid = vmask;
    rsp_ready = '0;
    g   = model_pick(vmask);
    exp = model_alu(op_a[g], op_b[g], op_c[g]);
    #1;
    chk("req_ready_idle", 32'(req_ready), oh(g));
    chk("busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    if (RrEn) model_ptr = (g + 1) % N;
    req_valid = bg;
    chk("busy_exec", 32'(busy), 32'd1);
    chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
    chk("req_ready_exec", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid_resp", 32'(rsp_valid), oh(g));
    chk("rsp_result", rsp_result, exp);
    rsp_ready = N'(~oh(g));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), oh(g));
      chk("hold_result", rsp_result, exp);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = N'(oh(g));
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '0;
    chk("busy_done", 32'(busy), 32'd0);
    chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      op_c[i] = '0;
    end
    drive_srcs();

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD on requester 0
    op_a[0] = 32'h0000_0005; op_b[0] = 32'h0000_0007; op_c[0] = 3'b000;
    transact(3'b001, 3'b000, 0);

    // AND on requester 1 with backpressure while requester 0 waits
    op_a[1] = 32'hF0F0_F0F0; op_b[1] = 32'hFF00_FF00; op_c[1] = 3'b010;
    transact(3'b010, 3'b001, 5);

    // Reserved op code returns zero
    op_a[2] = 32'h1234_5678; op_b[2] = 32'h0000_0001; op_c[2] = 3'b111;
    transact(3'b100, 3'b000, 0);

    // Contention between requesters 0 and 1
    op_c[0] = 3'b001; op_c[1] = 3'b011;
    op_a[0] = 32'h0000_0010; op_b[0] = 32'h0000_0003;
    op_a[1] = 32'h0000_0100; op_b[1] = 32'h0000_0001;
    repeat (4) transact(3'b011, 3'b011, 0);

    // Requesters 0 and 2 around the pointer wrap
    op_c[2] = 3'b100; op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h0000_0001;
    transact(3'b101, 3'b000, 0);
    transact(3'b101, 3'b000, 1);

    // Reset during EXEC abandons the operation
    transact(3'b010, 3'b000, 0);
    @(negedge clk);
    drive_srcs();
    req_valid = 3'b001;
    @(posedge clk); #1;
    chk("midop_busy", 32'(busy), 32'd1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midop_rst_busy", 32'(busy), 32'd0);
    chk("midop_rst_valid", 32'(rsp_valid), 32'd0);
    chk("midop_rst_result", rsp_result, 32'd0);
    model_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    transact(3'b111, 3'b000, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = $urandom;
        op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : $urandom;
        op_c[i] = 3'($urandom_range(0, 7));
      end
      transact(N'($urandom_range(1, 7)), N'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
